// File: rtl/dcache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_arbiter
//  Description : Round-robin arbiter sharing one dcache port between the Mem
//                stage (port 0) and a secondary client (port 1).
//  Revision    : 1.0  initial release
// ============================================================================

module dcache_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        req_en,
   input  logic [1:0]        req_wren,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [DATA_W-1:0] req_rdata0,
   output logic [DATA_W-1:0] req_rdata1,
   output logic [1:0]        req_done,
   output logic              dcache_en,
   output logic              dcache_wren,
   output logic [ADDR_W-1:0] dcache_addr,
   output logic [DATA_W-1:0] dcache_wdata,
   input  logic [DATA_W-1:0] dcache_rdata,
   input  logic              dcache_done,
   output logic              busy,
   output logic              overflow_err,
   output logic              timeout_err
);

   localparam int                 c_CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT    = c_CNT_W'(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT_M1 = c_CNT_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t              r_state;
   logic [1:0]          r_pend;
   logic [1:0]          r_wren;
   logic [ADDR_W-1:0]   r_addr0;
   logic [ADDR_W-1:0]   r_addr1;
   logic [DATA_W-1:0]   r_wdata0;
   logic [DATA_W-1:0]   r_wdata1;
   logic                r_owner;
   logic                r_last_grant;
   logic [c_CNT_W-1:0]  r_wait_cnt;

   logic                w_issue;
   logic                w_winner;
   logic                w_complete;
   logic [1:0]          w_clr;
   logic [1:0]          w_set;
   logic [1:0]          w_pend_next;
   logic                w_busy_next;
   logic                w_ovf;

   assign w_issue    = (r_state == S_IDLE) && (|r_pend);
   // With a single request pending the winner is that port; a tie goes to the non-last grantee.
   assign w_winner   = (r_pend == 2'b11) ? ~r_last_grant : r_pend[1];
   // dcache_done is ignored while the issue pulse is still on the bus.
   assign w_complete = (r_state == S_WAIT) && !dcache_en && dcache_done;
   assign w_clr      = w_complete ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
   assign w_set      = req_en & (~r_pend | w_clr);
   assign w_ovf      = |(req_en & r_pend & ~w_clr);
   assign w_pend_next = w_set | (r_pend & ~w_clr);
   assign w_busy_next = ((r_state == S_IDLE) ? w_issue : ~w_complete) | (|w_pend_next);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_pend       <= 2'b00;
         r_wren       <= 2'b00;
         r_addr0      <= '0;
         r_addr1      <= '0;
         r_wdata0     <= '0;
         r_wdata1     <= '0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_wait_cnt   <= '0;
         req_rdata0   <= '0;
         req_rdata1   <= '0;
         req_done     <= 2'b00;
         dcache_en    <= 1'b0;
         dcache_wren  <= 1'b0;
         dcache_addr  <= '0;
         dcache_wdata <= '0;
         busy         <= 1'b0;
         overflow_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         r_pend      <= w_pend_next;
         busy        <= w_busy_next;
         req_done    <= 2'b00;
         dcache_en   <= 1'b0;
         dcache_wren <= 1'b0;

         if (w_ovf) begin
            overflow_err <= 1'b1;
         end
         if (w_set[0]) begin
            r_wren[0] <= req_wren[0];
            r_addr0   <= req_addr0;
            r_wdata0  <= req_wdata0;
         end
         if (w_set[1]) begin
            r_wren[1] <= req_wren[1];
            r_addr1   <= req_addr1;
            r_wdata1  <= req_wdata1;
         end

         if (r_state == S_IDLE) begin
            if (w_issue) begin
               dcache_en    <= 1'b1;
               dcache_wren  <= w_winner ? r_wren[1] : r_wren[0];
               dcache_addr  <= w_winner ? r_addr1 : r_addr0;
               dcache_wdata <= w_winner ? r_wdata1 : r_wdata0;
               r_owner      <= w_winner;
               r_wait_cnt   <= '0;
               r_state      <= S_WAIT;
            end
         end else begin
            if (w_complete) begin
               if (r_owner) begin
                  req_rdata1 <= dcache_rdata;
               end else begin
                  req_rdata0 <= dcache_rdata;
               end
               req_done     <= w_clr;
               r_last_grant <= r_owner;
               r_state      <= S_IDLE;
            end else if (r_wait_cnt != c_TIMEOUT) begin
               // Saturating counter; the error is flagged but the wait continues.
               r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
               if (r_wait_cnt == c_TIMEOUT_M1) begin
                  timeout_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dcache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_arbiter
//  Description : Self-checking bench for dcache_arbiter with a dcache responder
//                and a transaction-rule reference model.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_dcache_arbiter;

   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    req_en = 2'b00;
   logic [1:0]    req_wren = 2'b00;
   logic [AW-1:0] req_addr0 = '0;
   logic [AW-1:0] req_addr1 = '0;
   logic [DW-1:0] req_wdata0 = '0;
   logic [DW-1:0] req_wdata1 = '0;
   logic [DW-1:0] req_rdata0;
   logic [DW-1:0] req_rdata1;
   logic [1:0]    req_done;
   logic          dcache_en;
   logic          dcache_wren;
   logic [AW-1:0] dcache_addr;
   logic [DW-1:0] dcache_wdata;
   logic [DW-1:0] dcache_rdata = '0;
   logic          dcache_done = 1'b0;
   logic          busy;
   logic          overflow_err;
   logic          timeout_err;

   dcache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_en       (req_en),
      .req_wren     (req_wren),
      .req_addr0    (req_addr0),
      .req_addr1    (req_addr1),
      .req_wdata0   (req_wdata0),
      .req_wdata1   (req_wdata1),
      .req_rdata0   (req_rdata0),
      .req_rdata1   (req_rdata1),
      .req_done     (req_done),
      .dcache_en    (dcache_en),
      .dcache_wren  (dcache_wren),
      .dcache_addr  (dcache_addr),
      .dcache_wdata (dcache_wdata),
      .dcache_rdata (dcache_rdata),
      .dcache_done  (dcache_done),
      .busy         (busy),
      .overflow_err (overflow_err),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model: pending requests per port plus the one in-flight access.
   logic [1:0]    m_pv, m_pw;
   logic [AW-1:0] m_pa [2];
   logic [DW-1:0] m_pd [2];
   logic          m_last, m_inwait, m_own;
   int            m_wcnt;
   logic          m_en, m_wren, m_busy, m_ovf, m_to;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [1:0]    m_done;
   logic [DW-1:0] m_rdata [2];

   // Responder controls and observations.
   int            resp_delay = 1;
   int            due = -1;
   logic          noise = 1'b0;
   logic          fixed_rd_v = 1'b0;
   logic [DW-1:0] fixed_rd = '0;
   int            en_cyc[$];
   logic [AW-1:0] en_addr[$];
   logic [DW-1:0] en_wdata[$];
   logic          en_wren[$];
   int            done_port[$];
   int            last_done[2];
   int            n_wren;
   int            to_cyc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pv = 2'b00; m_pw = 2'b00;
      m_pa[0] = '0; m_pa[1] = '0; m_pd[0] = '0; m_pd[1] = '0;
      m_last = 1'b1; m_inwait = 1'b0; m_own = 1'b0; m_wcnt = 0;
      m_en = 1'b0; m_wren = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
      m_addr = '0; m_wdata = '0; m_done = 2'b00;
      m_rdata[0] = '0; m_rdata[1] = '0;
   endtask

   // Advance the model across one rising edge using the inputs now driven.
   task automatic model_update();
      logic       was_issue;
      logic [1:0] clr;
      int         w;
      was_issue = m_en;
      m_en = 1'b0; m_wren = 1'b0; m_done = 2'b00; clr = 2'b00;
      if (m_inwait) begin
         if (!was_issue && dcache_done) begin
            m_rdata[m_own] = dcache_rdata;
            m_done[m_own]  = 1'b1;
            clr[m_own]     = 1'b1;
            m_last   = m_own;
            m_inwait = 1'b0;
         end else if (m_wcnt < TMO) begin
            m_wcnt++;
            if (m_wcnt == TMO) m_to = 1'b1;
         end
      end else if (m_pv != 2'b00) begin
         if (m_pv == 2'b11) w = m_last ? 0 : 1;
         else               w = m_pv[0] ? 0 : 1;
         m_en = 1'b1; m_wren = m_pw[w]; m_addr = m_pa[w]; m_wdata = m_pd[w];
         m_own = w[0]; m_inwait = 1'b1; m_wcnt = 0;
      end
      for (int i = 0; i < 2; i++) begin
         if (req_en[i]) begin
            if (m_pv[i] && !clr[i]) begin
               m_ovf = 1'b1;
            end else begin
               m_pv[i] = 1'b1;
               m_pw[i] = req_wren[i];
               m_pa[i] = (i == 0) ? req_addr0 : req_addr1;
               m_pd[i] = (i == 0) ? req_wdata0 : req_wdata1;
            end
         end else if (clr[i]) begin
            m_pv[i] = 1'b0;
         end
      end
      m_busy = m_inwait || (m_pv != 2'b00);
   endtask

   task automatic clear_obs();
      en_cyc.delete(); en_addr.delete(); en_wdata.delete(); en_wren.delete();
      done_port.delete();
      last_done[0] = -1; last_done[1] = -1;
      n_wren = 0; to_cyc = -1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_en = 2'b00; req_wren = 2'b00; dcache_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      due = -1;
      model_update();
   endtask

   // One clock: compare outputs with the model, drive requests and the dcache response.
   task automatic step(input logic [1:0] en, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      int dly;
      @(negedge clk);
      cyc++;
      chk("dcache_en", dcache_en, m_en);
      chk("dcache_wren", dcache_wren, m_wren);
      chk("dcache_addr", dcache_addr, m_addr);
      chk("dcache_wdata", dcache_wdata, m_wdata);
      chk("req_done", req_done, m_done);
      chk("req_rdata0", req_rdata0, m_rdata[0]);
      chk("req_rdata1", req_rdata1, m_rdata[1]);
      chk("busy", busy, m_busy);
      chk("overflow_err", overflow_err, m_ovf);
      chk("timeout_err", timeout_err, m_to);
      if (dcache_en) begin
         en_cyc.push_back(cyc); en_addr.push_back(dcache_addr);
         en_wdata.push_back(dcache_wdata); en_wren.push_back(dcache_wren);
      end
      if (dcache_wren) n_wren++;
      for (int p = 0; p < 2; p++) begin
         if (req_done[p]) begin
            done_port.push_back(p);
            last_done[p] = cyc;
         end
      end
      if (timeout_err && to_cyc < 0) to_cyc = cyc;

      req_en = en; req_wren = wr;
      req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
      dcache_rdata = fixed_rd_v ? fixed_rd : {$urandom, $urandom};
      if (m_en) begin
         dly = (resp_delay == 0) ? $urandom_range(1, 3) : resp_delay;
         due = cyc + dly;
         dcache_done = noise ? $urandom_range(0, 1) == 1 : 1'b0;
      end else if (m_inwait) begin
         dcache_done = (cyc == due);
      end else begin
         dcache_done = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      model_update();
   endtask

   task automatic idle(input int n);
      repeat (n) step(2'b00, 2'b00, '0, '0, '0, '0);
   endtask

   initial begin
      int s;
      model_reset();
      clear_obs();

      // Single read on port 0.
      do_reset(); clear_obs();
      fixed_rd_v = 1'b1; fixed_rd = 64'hDEADBEEF; resp_delay = 1;
      step(2'b01, 2'b00, 64'h1000, '0, '0, '0); s = cyc;
      idle(6);
      chk("t1_n_issue", en_cyc.size(), 1);
      if (en_cyc.size() > 0) begin
         chk("t1_en_latency", en_cyc[0] - s, 2);
         chk("t1_addr", en_addr[0], 64'h1000);
         chk("t1_wren", en_wren[0], 0);
      end
      chk("t1_done_latency", last_done[0] - s, 4);
      chk("t1_rdata0", req_rdata0, 64'hDEADBEEF);
      fixed_rd_v = 1'b0;

      // Simultaneous requests, then round-robin after a lone port-0 access.
      do_reset(); clear_obs();
      step(2'b11, 2'b00, 64'hA0, 64'hA1, '0, '0);
      idle(10);
      step(2'b01, 2'b00, 64'hB0, '0, '0, '0);
      idle(6);
      step(2'b11, 2'b00, 64'hC0, 64'hC1, '0, '0);
      idle(10);
      chk("t2_n_done", done_port.size(), 5);
      if (done_port.size() == 5) begin
         chk("t2_first", done_port[0], 0);
         chk("t2_second", done_port[1], 1);
         chk("t2_rr_first", done_port[3], 1);
         chk("t2_rr_second", done_port[4], 0);
      end

      // Write pass-through on port 1.
      do_reset(); clear_obs();
      step(2'b10, 2'b10, '0, 64'h2008, '0, 64'h55AA);
      idle(6);
      chk("t3_wren_cycles", n_wren, 1);
      if (en_cyc.size() > 0) begin
         chk("t3_addr", en_addr[0], 64'h2008);
         chk("t3_wdata", en_wdata[0], 64'h55AA);
         chk("t3_wren", en_wren[0], 1);
      end
      chk("t3_done_port", (done_port.size() == 1) ? done_port[0] : -1, 1);

      // Overflow: extra pulses while port 0 is pending or waiting.
      do_reset(); clear_obs(); resp_delay = 3;
      step(2'b01, 2'b00, 64'h3000, '0, '0, '0);
      step(2'b01, 2'b00, 64'h3100, '0, '0, '0);
      idle(1);
      step(2'b01, 2'b00, 64'h3200, '0, '0, '0);
      idle(8);
      chk("t4_n_issue", en_cyc.size(), 1);
      if (en_cyc.size() > 0) chk("t4_addr", en_addr[0], 64'h3000);
      chk("t4_overflow", overflow_err, 1);

      // Re-request on the completion edge.
      do_reset(); clear_obs(); resp_delay = 1;
      step(2'b01, 2'b00, 64'h4000, '0, '0, '0); s = cyc;
      idle(2);
      step(2'b01, 2'b00, 64'h4100, '0, '0, '0);
      idle(6);
      chk("t5_done0", (done_port.size() > 0) ? done_port[0] : -1, 0);
      chk("t5_done_cyc", (done_port.size() > 0) ? 1 : 0, 1);
      chk("t5_n_issue", en_cyc.size(), 2);
      if (en_cyc.size() == 2) begin
         chk("t5_reissue_cyc", en_cyc[1] - s, 5);
         chk("t5_reissue_addr", en_addr[1], 64'h4100);
      end
      chk("t5_no_overflow", overflow_err, 0);

      // Randomized traffic with spurious dcache_done in idle and issue cycles.
      do_reset(); clear_obs(); noise = 1'b1; resp_delay = 0;
      repeat (400) begin
         step({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
              2'($urandom_range(0, 3)),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom});
      end
      noise = 1'b0;
      idle(8);

      // Timeout with no dcache_done.
      do_reset(); clear_obs(); resp_delay = 1000;
      step(2'b01, 2'b00, 64'h5000, '0, '0, '0);
      idle(8);
      if (en_cyc.size() > 0) chk("t6_timeout_cyc", to_cyc - en_cyc[0], 4);
      chk("t6_timeout", timeout_err, 1);
      chk("t6_busy", busy, 1);

      // Asynchronous reset while still waiting.
      #3 reset_n = 1'b0;
      #1;
      chk("rst_dcache_en", dcache_en, 0);
      chk("rst_dcache_wren", dcache_wren, 0);
      chk("rst_dcache_addr", dcache_addr, 0);
      chk("rst_dcache_wdata", dcache_wdata, 0);
      chk("rst_req_done", req_done, 0);
      chk("rst_rdata0", req_rdata0, 0);
      chk("rst_rdata1", req_rdata1, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow_err, 0);
      chk("rst_timeout", timeout_err, 0);
      do_reset(); clear_obs(); resp_delay = 1; noise = 1'b1;
      idle(6);
      noise = 1'b0;
      chk("rst_no_done", done_port.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
